dvp_csr_bank: RTL and testbench

Parametrised APB control/status register bank for the multi-channel DVP video pipeline (VI/VP/VO stages). It serves CH_NUM independent channel register pages plus one global page. Per-channel configuration is double-buffered: software writes staging registers, and the active copies driven to the pipeline update only on that channel's frame boundary (vsync rising edge). It also adds per-channel frame counters, frame-start interrupts with write-1-to-clear, and bus error reporting.

---
 rtl/dvp_csr_bank.sv | 237 +++++++++++++++++++++++
 tb/tb_dvp_csr_bank.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dvp_csr_bank.sv
`timescale 1ns/1ps
// dvp_csr_bank
//   APB register bank for the multi-channel DVP video pipeline. It has one
//   register page per channel (pages 0..CH_NUM-1) and one global page (page 7).
//   Each channel holds staged CR/START/END/SCALER registers, a frame counter
//   and a frame-start interrupt. The interrupt clears by writing 1 to its bit.
//
//   Optional feature macro: DVP_CSR_SHADOW_EN
//     defined   : the staged registers are double-buffered. The active copies
//                 load on the channel's vsync rising edge. While the channel
//                 is disabled (active CR[0] = 0), a write also loads the
//                 active copy at once.
//     undefined : there is one register set per channel, and writes drive
//                 the outputs directly. upd_pend always reads 0.
//
// Ports
//   clk, rst_n           clock (also samples vsync), async active-low reset
//   io_apb_*             APB slave: zero wait states, combinational PRDATA
//   vsync_i[CH_NUM]      per-channel vsync, asynchronous to clk
//   status_i[16*CH_NUM]  per-channel live status, shown in SR
//   cr_o/start_o/end_o/scaler_o [32*CH_NUM]  active registers, channel n at [32n+:32]
//   irq_o                OR of (IRQ_PEND & IRQ_EN)
module dvp_csr_bank #(
  parameter int         CH_NUM  = 2,
  parameter logic [7:0] VERSION = 8'h02
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [5:0]             io_apb_PADDR,
  input  logic                   io_apb_PSEL,
  input  logic                   io_apb_PENABLE,
  input  logic                   io_apb_PWRITE,
  input  logic [31:0]            io_apb_PWDATA,
  output logic                   io_apb_PREADY,
  output logic [31:0]            io_apb_PRDATA,
  output logic                   io_apb_PSLVERROR,
  input  logic [CH_NUM-1:0]      vsync_i,
  input  logic [16*CH_NUM-1:0]   status_i,
  output logic [32*CH_NUM-1:0]   cr_o,
  output logic [32*CH_NUM-1:0]   start_o,
  output logic [32*CH_NUM-1:0]   end_o,
  output logic [32*CH_NUM-1:0]   scaler_o,
  output logic                   irq_o
);

  logic [2:0] page;
  logic [2:0] rsel;
  logic       page_is_ch;
  logic       page_is_glob;
  logic       acc;
  logic       err;
  logic       wr_ok;
  logic       rd_ok;

  assign page         = io_apb_PADDR[5:3];
  assign rsel         = io_apb_PADDR[2:0];
  assign page_is_ch   = ({29'd0, page} < 32'(CH_NUM));
  assign page_is_glob = (page == 3'd7);
  assign acc          = io_apb_PSEL & io_apb_PENABLE;

  // Unmapped registers and writes to read-only registers are errors.
  always_comb begin
    err = 1'b0;
    if (page_is_ch) begin
      if (rsel == 3'd6 || rsel == 3'd7)
        err = 1'b1;
      else if (io_apb_PWRITE && (rsel == 3'd1 || rsel == 3'd5))
        err = 1'b1;
    end else if (page_is_glob) begin
      if (rsel > 3'd2)
        err = 1'b1;
      else if (io_apb_PWRITE && rsel == 3'd2)
        err = 1'b1;
    end else begin
      err = 1'b1;
    end
  end

  assign wr_ok            = acc & io_apb_PWRITE & ~err;
  assign rd_ok            = acc & ~io_apb_PWRITE & ~err;
  assign io_apb_PSLVERROR = acc & err;
  assign io_apb_PREADY    = 1'b1;

  // vsync: two synchronizer flops, then one flop for rising-edge detection.
  logic [CH_NUM-1:0] sync1_reg;
  logic [CH_NUM-1:0] sync2_reg;
  logic [CH_NUM-1:0] sync3_reg;
  logic [CH_NUM-1:0] frame_evt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
      sync3_reg <= '0;
    end else begin
      sync1_reg <= vsync_i;
      sync2_reg <= sync1_reg;
      sync3_reg <= sync2_reg;
    end
  end

  assign frame_evt = sync2_reg & ~sync3_reg;

  // Global page: interrupt enable and pending bits.
  logic [CH_NUM-1:0] irq_en_reg;
  logic [CH_NUM-1:0] irq_pend_reg;
  logic [CH_NUM-1:0] irq_w1c;

  assign irq_w1c = (wr_ok && page_is_glob && rsel == 3'd1) ?
                   io_apb_PWDATA[CH_NUM-1:0] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en_reg   <= '0;
      irq_pend_reg <= '0;
    end else begin
      if (wr_ok && page_is_glob && rsel == 3'd0)
        irq_en_reg <= io_apb_PWDATA[CH_NUM-1:0];
      // When a frame event and a clear hit the same bit, the frame event wins.
      irq_pend_reg <= (irq_pend_reg & ~irq_w1c) | frame_evt;
    end
  end

  assign irq_o = |(irq_pend_reg & irq_en_reg);

  // Per-channel registers. Field index: 0 CR, 1 START, 2 END, 3 SCALER.
  logic [31:0]       stg_val [CH_NUM][4];
  logic [31:0]       act_val [CH_NUM][4];
  logic [15:0]       fcnt_val [CH_NUM];
  logic [CH_NUM-1:0] upd_pend;

  for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
    logic        ch_wr;
    logic [15:0] fcnt_reg;

    assign ch_wr = wr_ok & page_is_ch & (page == 3'(gi));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        fcnt_reg <= '0;
      else if (frame_evt[gi])
        fcnt_reg <= fcnt_reg + 16'd1;
    end
    assign fcnt_val[gi] = fcnt_reg;

`ifdef DVP_CSR_SHADOW_EN
    logic ch_en;
    logic stg_any_wr;
    logic upd_reg;

    assign ch_en      = act_val[gi][0][0];
    assign stg_any_wr = ch_wr & (rsel == 3'd0 || rsel == 3'd2 ||
                                 rsel == 3'd3 || rsel == 3'd4);

    // A write on the frame-event edge leaves the update pending.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        upd_reg <= 1'b0;
      else if (stg_any_wr)
        upd_reg <= 1'b1;
      else if (frame_evt[gi])
        upd_reg <= 1'b0;
    end
    assign upd_pend[gi] = upd_reg;
`else
    assign upd_pend[gi] = 1'b0;
`endif

    for (genvar gj = 0; gj < 4; gj++) begin : g_fld
      localparam logic [2:0] RA = (gj == 0) ? 3'd0 : 3'(gj + 1);
      logic        fld_wr;
      logic [31:0] stg_reg;

      assign fld_wr = ch_wr & (rsel == RA);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          stg_reg <= '0;
        else if (fld_wr)
          stg_reg <= io_apb_PWDATA;
      end
      assign stg_val[gi][gj] = stg_reg;

`ifdef DVP_CSR_SHADOW_EN
      logic [31:0] act_reg;
      // On a frame event, load the staging value from before this edge's write.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          act_reg <= '0;
        else if (frame_evt[gi])
          act_reg <= stg_reg;
        else if (fld_wr && !ch_en)
          act_reg <= io_apb_PWDATA;
      end
      assign act_val[gi][gj] = act_reg;
`else
      assign act_val[gi][gj] = stg_reg;
`endif
    end

    assign cr_o[32*gi +: 32]     = act_val[gi][0];
    assign start_o[32*gi +: 32]  = act_val[gi][1];
    assign end_o[32*gi +: 32]    = act_val[gi][2];
    assign scaler_o[32*gi +: 32] = act_val[gi][3];
  end

  // Read mux. Staged registers read back their staging value.
  always_comb begin
    io_apb_PRDATA = '0;
    if (rd_ok) begin
      if (page_is_glob) begin
        case (rsel)
          3'd0:    io_apb_PRDATA = 32'(irq_en_reg);
          3'd1:    io_apb_PRDATA = 32'(irq_pend_reg);
          3'd2:    io_apb_PRDATA = {16'h4456, 8'(CH_NUM), VERSION};
          default: io_apb_PRDATA = '0;
        endcase
      end else begin
        for (int i = 0; i < CH_NUM; i++) begin
          if (page == 3'(i)) begin
            case (rsel)
              3'd0:    io_apb_PRDATA = stg_val[i][0];
              3'd1:    io_apb_PRDATA = {14'd0, upd_pend[i], irq_pend_reg[i],
                                        status_i[16*i +: 16]};
              3'd2:    io_apb_PRDATA = stg_val[i][1];
              3'd3:    io_apb_PRDATA = stg_val[i][2];
              3'd4:    io_apb_PRDATA = stg_val[i][3];
              3'd5:    io_apb_PRDATA = {16'd0, fcnt_val[i]};
              default: io_apb_PRDATA = '0;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dvp_csr_bank.sv
`timescale 1ns/1ps
// Directed testbench for dvp_csr_bank (CH_NUM = 2). Expected values are
// written by hand. Where the double-buffered build behaves differently, the
// expected value is chosen by SHADOW.
module tb_dvp_csr_bank;

`ifdef DVP_CSR_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  PADDR;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PWDATA;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERROR;
  logic [1:0]  vsync_i;
  logic [31:0] status_i;
  logic [63:0] cr_o, start_o, end_o, scaler_o;
  logic        irq_o;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] rdata;
  logic        rerr;

  always #5 clk = ~clk;

  dvp_csr_bank #(.CH_NUM(2), .VERSION(8'h02)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .io_apb_PADDR     (PADDR),
    .io_apb_PSEL      (PSEL),
    .io_apb_PENABLE   (PENABLE),
    .io_apb_PWRITE    (PWRITE),
    .io_apb_PWDATA    (PWDATA),
    .io_apb_PREADY    (PREADY),
    .io_apb_PRDATA    (PRDATA),
    .io_apb_PSLVERROR (PSLVERROR),
    .vsync_i          (vsync_i),
    .status_i         (status_i),
    .cr_o             (cr_o),
    .start_o          (start_o),
    .end_o            (end_o),
    .scaler_o         (scaler_o),
    .irq_o            (irq_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // Call this #1 after a posedge. It returns #1 after the commit edge.
  task automatic xfer(input logic wr, input logic [5:0] a, input logic [31:0] d);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
    @(posedge clk); #1 PENABLE = 1'b1;
    #1 rdata = PRDATA; rerr = PSLVERROR;
    @(posedge clk); #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    xfer(1'b1, a, d);
  endtask

  task automatic rd_chk(input string tag, input logic [5:0] a, input logic [31:0] exp);
    xfer(1'b0, a, 32'd0);
    chk(tag, rdata, exp);
  endtask

  task automatic vsync_pulse(input logic [1:0] m);
    vsync_i = vsync_i | m;
    repeat (3) @(posedge clk);
    #1 vsync_i = vsync_i & ~m;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Time an APB write so that its commit edge is the frame-event edge of channel ch.
  task automatic collide_write(input int ch, input logic [5:0] a, input logic [31:0] d);
    vsync_i[ch] = 1'b1;
    @(posedge clk); #1 PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(posedge clk); #1 PENABLE = 1'b1;
    @(posedge clk); #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    @(posedge clk); #1 vsync_i[ch] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Word addresses: {page, reg}
  localparam logic [5:0] A_CR0 = 6'd0,  A_SR0 = 6'd1,  A_START0 = 6'd2, A_FCNT0 = 6'd5;
  localparam logic [5:0] A_CR1 = 6'd8,  A_SR1 = 6'd9,  A_END1 = 6'd11, A_SCALER1 = 6'd12;
  localparam logic [5:0] A_FCNT1 = 6'd13;
  localparam logic [5:0] A_IRQEN = 6'd56, A_IRQPEND = 6'd57, A_ID = 6'd58;

  initial begin
    rst_n = 1'b0; PADDR = '0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PWDATA = '0; vsync_i = '0; status_i = 32'hBEEF_1234;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    chk("rst_cr",     cr_o[31:0] | cr_o[63:32], 32'd0);
    chk("rst_start",  start_o[31:0] | start_o[63:32], 32'd0);
    chk("rst_end",    end_o[31:0] | end_o[63:32], 32'd0);
    chk("rst_scaler", scaler_o[31:0] | scaler_o[63:32], 32'd0);
    chk("rst_irq",    32'(irq_o), 32'd0);
    chk("rst_pready", 32'(PREADY), 32'd1);
    chk("rst_slverr", 32'(PSLVERROR), 32'd0);
    chk("idle_prdata", PRDATA, 32'd0);
    rd_chk("id", A_ID, 32'h4456_0202);
    rd_chk("fcnt0_rst", A_FCNT0, 32'd0);
    rd_chk("sr0_rst", A_SR0, 32'h0000_1234);
    rd_chk("sr1_rst", A_SR1, 32'h0000_BEEF);

    // Configure channel 0 while it is disabled, then stage START0
    wr(A_CR0, 32'd1);
    chk("cr0_imm", cr_o[31:0], 32'd1);
    rd_chk("cr0_rd", A_CR0, 32'd1);
    wr(A_START0, 32'h0010_0020);
    chk("wr_ok_err", 32'(rerr), 32'd0);
    chk("start0_staged", start_o[31:0], SHADOW ? 32'd0 : 32'h0010_0020);
    rd_chk("start0_rd", A_START0, 32'h0010_0020);
    rd_chk("sr0_upd", A_SR0, SHADOW ? 32'h0002_1234 : 32'h0000_1234);
    wr(A_END1, 32'hAAAA_5555);
    chk("end1_imm", end_o[63:32], 32'hAAAA_5555);
    wr(A_IRQEN, 32'd1);
    rd_chk("irqen_rd", A_IRQEN, 32'd1);

    // vsync0 -> frame event: the outputs change on the 3rd edge
    vsync_i[0] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("vs_e2_start", start_o[31:0], SHADOW ? 32'd0 : 32'h0010_0020);
    chk("vs_e2_irq", 32'(irq_o), 32'd0);
    @(posedge clk); #1;
    chk("vs_e3_start", start_o[31:0], 32'h0010_0020);
    chk("vs_e3_irq", 32'(irq_o), 32'd1);
    vsync_i[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rd_chk("sr0_after", A_SR0, 32'h0001_1234);
    rd_chk("fcnt0_1", A_FCNT0, 32'd1);
    rd_chk("pend_01", A_IRQPEND, 32'd1);
    wr(A_IRQPEND, 32'd1);
    chk("irq_clr", 32'(irq_o), 32'd0);
    rd_chk("pend_00", A_IRQPEND, 32'd0);

    // Collisions on channel 1
    wr(A_CR1, 32'd1);
    chk("cr1_imm", cr_o[63:32], 32'd1);
    wr(A_SCALER1, 32'h11);
    chk("scl1_staged", scaler_o[63:32], SHADOW ? 32'd0 : 32'h11);
    collide_write(1, A_SCALER1, 32'h22);
    chk("scl1_collide", scaler_o[63:32], SHADOW ? 32'h11 : 32'h22);
    rd_chk("scl1_rd", A_SCALER1, 32'h22);
    rd_chk("sr1_collide", A_SR1, SHADOW ? 32'h0003_BEEF : 32'h0001_BEEF);
    rd_chk("fcnt1_1", A_FCNT1, 32'd1);
    vsync_pulse(2'b10);
    chk("scl1_next", scaler_o[63:32], 32'h22);
    rd_chk("sr1_next", A_SR1, 32'h0001_BEEF);
    collide_write(1, A_IRQPEND, 32'd2);
    rd_chk("w1c_collide", A_IRQPEND, 32'd2);
    rd_chk("fcnt1_3", A_FCNT1, 32'd3);
    wr(A_IRQPEND, 32'd2);
    rd_chk("w1c_bit1", A_IRQPEND, 32'd0);

    // Interrupts from both channels
    vsync_pulse(2'b11);
    rd_chk("pend_11", A_IRQPEND, 32'd3);
    chk("irq_both", 32'(irq_o), 32'd1);
    wr(A_IRQPEND, 32'd1);
    chk("irq_masked", 32'(irq_o), 32'd0);
    rd_chk("pend_10", A_IRQPEND, 32'd2);
    wr(A_IRQEN, 32'd2);
    chk("irq_en1", 32'(irq_o), 32'd1);
    wr(A_IRQPEND, 32'd2);
    chk("irq_off", 32'(irq_o), 32'd0);
    rd_chk("fcnt0_2", A_FCNT0, 32'd2);
    rd_chk("fcnt1_4", A_FCNT1, 32'd4);

    // Bus errors
    wr(A_FCNT0, 32'd5);
    chk("err_wr_fcnt", 32'(rerr), 32'd1);
    rd_chk("fcnt0_kept", A_FCNT0, 32'd2);
    xfer(1'b0, 6'd24, 32'd0);
    chk("err_rd_pg3", 32'(rerr), 32'd1);
    chk("err_rd_pg3_data", rdata, 32'd0);
    wr(6'd6, 32'hFFFF_FFFF);
    chk("err_wr_r6", 32'(rerr), 32'd1);
    rd_chk("cr0_kept", A_CR0, 32'd1);
    wr(6'd16, 32'hDEAD_0000);
    chk("err_wr_pg2", 32'(rerr), 32'd1);
    chk("cr_kept", cr_o[31:0] ^ cr_o[63:32], 32'd0);
    chk("cr0_out_kept", cr_o[31:0], 32'd1);
    xfer(1'b0, 6'd59, 32'd0);
    chk("err_rd_g3", 32'(rerr), 32'd1);
    chk("err_rd_g3_data", rdata, 32'd0);
    wr(A_ID, 32'd0);
    chk("err_wr_id", 32'(rerr), 32'd1);
    wr(A_SR0, 32'hFFFF_FFFF);
    chk("err_wr_sr", 32'(rerr), 32'd1);
    rd_chk("sr0_kept", A_SR0, 32'h0000_1234);

    // Frame counter wrap
    force dut.g_ch[0].fcnt_reg = 16'hFFFF;
    @(posedge clk); #1 release dut.g_ch[0].fcnt_reg;
    rd_chk("fcnt0_max", A_FCNT0, 32'h0000_FFFF);
    vsync_pulse(2'b01);
    rd_chk("fcnt0_wrap", A_FCNT0, 32'd0);

    // A reset in mid-frame discards the pending update
    wr(A_START0, 32'h0000_5555);
    chk("start0_pre_rst", start_o[31:0], SHADOW ? 32'h0010_0020 : 32'h0000_5555);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst2_start", start_o[31:0], 32'd0);
    chk("rst2_cr", cr_o[31:0] | cr_o[63:32], 32'd0);
    rd_chk("rst2_sr0", A_SR0, 32'h0000_1234);
    rd_chk("rst2_irqen", A_IRQEN, 32'd0);
    vsync_pulse(2'b01);
    chk("rst2_no_load", start_o[31:0], 32'd0);
    rd_chk("rst2_fcnt0", A_FCNT0, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
